// File: rtl/mram_conv_port_a_arbiter.sv
// rtl/mram_conv_port_a_arbiter.sv - Round-robin Port A arbiter with zero-fill sequencer for the conv-model MRAM
//
// Purpose:
//   Lets two requesters share MRAM Port A: Conv2D (requester 0) and MaxPool (requester 1).
//   Each request uses a valid/ready handshake. Reads return with a fixed two-cycle latency.
//   A clear sequencer zero-fills the whole array, one word per cycle.
//
// Ports:
//   clk, resetn                      clock (rising edge), asynchronous active-low reset
//   c_valid/c_ready/c_addr/c_wdata   Conv2D request; c_we is the byte enable set, 0 means read
//   c_rvalid/c_rdata                 Conv2D read return
//   p_*                              same signals for MaxPool
//   clear_start                      pulse that starts a zero-fill
//   clear_busy/clear_done            zero-fill in progress / completion pulse
//   mram_en_a/we_a/addr_a/din_a      registered MRAM Port A command
//   mram_dout_a                      MRAM read data, valid one cycle after mram_en_a

module mram_conv_port_a_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    c_valid,
  output logic                    c_ready,
  input  logic [ADDR_WIDTH-1:0]   c_addr,
  input  logic [DATA_WIDTH-1:0]   c_wdata,
  input  logic [DATA_WIDTH/8-1:0] c_we,
  output logic                    c_rvalid,
  output logic [DATA_WIDTH-1:0]   c_rdata,
  input  logic                    p_valid,
  output logic                    p_ready,
  input  logic [ADDR_WIDTH-1:0]   p_addr,
  input  logic [DATA_WIDTH-1:0]   p_wdata,
  input  logic [DATA_WIDTH/8-1:0] p_we,
  output logic                    p_rvalid,
  output logic [DATA_WIDTH-1:0]   p_rdata,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    clear_done,
  output logic                    mram_en_a,
  output logic [DATA_WIDTH/8-1:0] mram_we_a,
  output logic [ADDR_WIDTH-1:0]   mram_addr_a,
  output logic [DATA_WIDTH-1:0]   mram_din_a,
  input  logic [DATA_WIDTH-1:0]   mram_dout_a
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {SERVE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  r_en, w_en_nxt;
  logic [BE_WIDTH-1:0]   r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_din, w_din_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  // Read-return pipeline: stage 1 is (r_rd_v, r_rd_own); stage 2 is the rvalid registers.
  logic                  r_rd_v, w_rd_v_nxt;
  logic                  r_rd_own, w_rd_own_nxt;
  logic                  r_c_rvalid, r_p_rvalid;

  logic                  w_gnt_c, w_gnt_p, w_serve, w_c_ready, w_p_ready, w_hs;
  logic [BE_WIDTH-1:0]   w_sel_we;

  // On a tie, grant the requester that was not served last.
  assign w_gnt_p   = p_valid && (!c_valid || !r_last_grant);
  assign w_gnt_c   = c_valid && !w_gnt_p;
  // clear_start wins over any request arriving in the same cycle.
  assign w_serve   = (r_state == SERVE) && !clear_start;
  assign w_c_ready = w_gnt_c && w_serve;
  assign w_p_ready = w_gnt_p && w_serve;
  assign w_hs      = w_c_ready || w_p_ready;
  assign w_sel_we  = w_p_ready ? p_we : c_we;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_en_nxt     = 1'b0;
    w_we_nxt     = '0;
    w_addr_nxt   = r_addr;
    w_din_nxt    = r_din;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_rd_v_nxt   = 1'b0;
    w_rd_own_nxt = r_rd_own;
    case (r_state)
      SERVE: begin
        if (clear_start) begin
          // The first zero-fill write goes out with the entry into CLEAR.
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          w_en_nxt    = 1'b1;
          w_we_nxt    = '1;
          w_addr_nxt  = '0;
          w_din_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end else if (w_hs) begin
          w_en_nxt     = 1'b1;
          w_we_nxt     = w_sel_we;
          w_addr_nxt   = w_p_ready ? p_addr : c_addr;
          w_din_nxt    = w_p_ready ? p_wdata : c_wdata;
          w_rd_v_nxt   = (w_sel_we == '0);
          w_rd_own_nxt = w_p_ready;
        end
      end
      CLEAR: begin
        // r_cnt is the address being written this cycle.
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = SERVE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt  = r_cnt + 1'b1;
          w_en_nxt   = 1'b1;
          w_we_nxt   = '1;
          w_addr_nxt = r_cnt + 1'b1;
          w_din_nxt  = '0;
          w_busy_nxt = 1'b1;
        end
      end
      default: w_state_nxt = SERVE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= SERVE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_en         <= 1'b0;
      r_we         <= '0;
      r_addr       <= '0;
      r_din        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_v       <= 1'b0;
      r_rd_own     <= 1'b0;
      r_c_rvalid   <= 1'b0;
      r_p_rvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_en       <= w_en_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_din      <= w_din_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_rd_v     <= w_rd_v_nxt;
      r_rd_own   <= w_rd_own_nxt;
      r_c_rvalid <= r_rd_v && !r_rd_own;
      r_p_rvalid <= r_rd_v && r_rd_own;
      if (w_hs) begin
        r_last_grant <= w_p_ready;
      end
    end
  end

  assign c_ready     = w_c_ready;
  assign p_ready     = w_p_ready;
  assign c_rvalid    = r_c_rvalid;
  assign p_rvalid    = r_p_rvalid;
  // Both requesters see the MRAM data; only the owner's rvalid qualifies it.
  assign c_rdata     = mram_dout_a;
  assign p_rdata     = mram_dout_a;
  assign clear_busy  = r_busy;
  assign clear_done  = r_done;
  assign mram_en_a   = r_en;
  assign mram_we_a   = r_we;
  assign mram_addr_a = r_addr;
  assign mram_din_a  = r_din;

endmodule

// File: tb/tb_mram_conv_port_a_arbiter.sv
// tb/tb_mram_conv_port_a_arbiter.sv - Self-checking bench for mram_conv_port_a_arbiter

module tb_mram_conv_port_a_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk, resetn;
  logic          c_valid, c_ready, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic [3:0]    c_we;
  logic          p_valid, p_ready, p_rvalid;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic [3:0]    p_we;
  logic          clear_start, clear_busy, clear_done;
  logic          mram_en_a;
  logic [3:0]    mram_we_a;
  logic [AW-1:0] mram_addr_a;
  logic [DW-1:0] mram_din_a, mram_dout_a;

  mram_conv_port_a_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_wdata(c_wdata), .c_we(c_we),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_wdata(p_wdata), .p_we(p_we),
    .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .mram_en_a(mram_en_a), .mram_we_a(mram_we_a), .mram_addr_a(mram_addr_a),
    .mram_din_a(mram_din_a), .mram_dout_a(mram_dout_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MRAM Port A model: byte-enabled writes, registered read data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mram_en_a) begin
      for (int b = 0; b < 4; b++)
        if (mram_we_a[b]) mem[mram_addr_a][b*8 +: 8] <= mram_din_a[b*8 +: 8];
      if (mram_we_a == 4'h0) mram_dout_a <= mem[mram_addr_a];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            owner;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            checks = 0;
  int            errors = 0;
  int            done_count = 0;
  int            busy_count = 0;
  int            rv_count = 0;
  logic [DW-1:0] last_c_rdata = '0;
  logic [DW-1:0] last_p_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en_we"}, {mram_en_a, mram_we_a}, 0);
    check({tag, "_addr"}, mram_addr_a, 0);
    check({tag, "_din"}, mram_din_a, 0);
    check({tag, "_flags"}, {c_rvalid, p_rvalid, clear_busy, clear_done}, 0);
  endtask

  task automatic shadow_write(input logic [AW-1:0] a, input logic [3:0] we, input logic [DW-1:0] d);
    for (int b = 0; b < 4; b++)
      if (we[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sb.delete();
      end else begin
        if (clear_done) done_count++;
        if (clear_busy) busy_count++;
        if (c_valid && p_valid) check("one_ready", c_ready & p_ready, 0);
        if (c_rvalid || p_rvalid) begin
          rv_count++;
          check("rv_both", c_rvalid & p_rvalid, 0);
          checks++;
          assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL rv_unexpected: observed rvalid c=%0b p=%0b expected no pending read", c_rvalid, p_rvalid);
          end
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rv_owner", p_rvalid, e.owner);
            check("rv_data", p_rvalid ? p_rdata : c_rdata, e.data);
            check("rv_latency", cyc, e.cyc + 2);
            if (p_rvalid) last_p_rdata = p_rdata;
            else last_c_rdata = c_rdata;
          end
        end
        if (c_valid && c_ready) begin
          if (c_we == 4'h0) sb.push_back('{1'b0, shadow[c_addr], cyc});
          else shadow_write(c_addr, c_we, c_wdata);
        end
        if (p_valid && p_ready) begin
          if (p_we == 4'h0) sb.push_back('{1'b1, shadow[p_addr], cyc});
          else shadow_write(p_addr, p_we, p_wdata);
        end
      end
    end
  endtask

  initial begin
    int dc, bc, rc, k;
    resetn = 1'b0;
    c_valid = 0; c_addr = '0; c_wdata = '0; c_we = '0;
    p_valid = 0; p_addr = '0; p_wdata = '0; p_we = '0;
    clear_start = 0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) tick();
    check_zero("reset");
    resetn = 1'b1;
    tick();

    // Conv2D write then read of address 5
    c_valid = 1; c_addr = 5; c_we = 4'hF; c_wdata = 32'hDEADBEEF;
    @(negedge clk); check("wr_ready", c_ready, 1);
    tick();
    c_we = 4'h0;
    check("wr_issue", {mram_en_a, mram_we_a, mram_addr_a, mram_din_a}, {1'b1, 4'hF, 10'd5, 32'hDEADBEEF});
    @(negedge clk); check("rd_ready", c_ready, 1);
    tick();
    c_valid = 0;
    check("rd_issue", {mram_en_a, mram_we_a, mram_addr_a}, {1'b1, 4'h0, 10'd5});
    tick();
    check("rd_return", {c_rvalid, c_rdata}, {1'b1, 32'hDEADBEEF});

    // MaxPool full write then byte write to address 9
    p_valid = 1; p_addr = 9; p_we = 4'hF; p_wdata = 32'h11223344;
    @(negedge clk); check("p_wr_ready", p_ready, 1);
    tick();
    p_we = 4'b0100; p_wdata = 32'h00AA0000;
    @(negedge clk); check("p_bwr_ready", p_ready, 1);
    tick();

    // Tie: both read for 4 cycles, grants alternate starting with Conv2D
    c_valid = 1; c_addr = 5; c_we = 4'h0;
    p_valid = 1; p_addr = 9; p_we = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tie_c_ready", c_ready, (i % 2) == 0);
      check("tie_p_ready", p_ready, (i % 2) == 1);
      tick();
    end
    c_valid = 0; p_valid = 0;
    repeat (3) tick();
    check("byte_merge", last_p_rdata, 32'h11AA3344);
    check("c_readback", last_c_rdata, 32'hDEADBEEF);

    // Clear colliding with a Conv2D request
    c_valid = 1; c_addr = 5; c_we = 4'h0;
    clear_start = 1;
    @(negedge clk); check("clr_blocks_ready", c_ready, 0);
    tick();
    clear_start = 0;
    for (int a = 0; a < (1 << AW); a++) shadow[a] = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      check("clr_write", {clear_busy, mram_en_a, mram_we_a, mram_addr_a, mram_din_a, c_ready},
            {1'b1, 1'b1, 4'hF, i[AW-1:0], 32'h0, 1'b0});
      @(posedge clk); #1;
    end
    @(negedge clk); check("clr_done", {clear_done, clear_busy, c_ready}, {1'b1, 1'b0, 1'b1});
    tick();
    c_valid = 0;
    @(negedge clk); check("clr_done_pulse", clear_done, 0);
    repeat (3) tick();
    check("post_clear_read", last_c_rdata, 32'h0);

    // Read just before a clear, plus a second clear_start during CLEAR
    c_valid = 1; c_addr = 7; c_we = 4'hF; c_wdata = 32'h12345678;
    tick();
    c_we = 4'h0;
    tick();
    c_valid = 0;
    dc = done_count; bc = busy_count;
    clear_start = 1;
    tick();
    clear_start = 0;
    for (int a = 0; a < (1 << AW); a++) shadow[a] = '0;
    repeat (9) tick();
    clear_start = 1;
    tick();
    clear_start = 0;
    for (k = 0; k < 1100 && done_count == dc; k++) tick();
    repeat (20) tick();
    check("clr2_done_once", done_count - dc, 1);
    check("clr2_busy_len", busy_count - bc, 1 << AW);
    check("pre_clear_read", last_c_rdata, 32'h12345678);

    // Reset at clear counter 300
    clear_start = 1;
    tick();
    clear_start = 0;
    for (k = 0; k < 400 && mram_addr_a != 10'd300; k++) tick();
    check("clr3_reach_300", mram_addr_a, 300);
    #2 resetn = 1'b0;
    #1 check_zero("rst_mid_clear");
    dc = done_count;
    tick(); tick();
    resetn = 1'b1;
    repeat (20) tick();
    check("no_done_after_rst", done_count - dc, 0);
    check("idle_after_rst", {clear_busy, mram_en_a}, 0);

    // Reset with a read in flight
    rc = rv_count;
    c_valid = 1; c_addr = 5; c_we = 4'h0;
    @(negedge clk); check("flight_ready", c_ready, 1);
    tick();
    c_valid = 0;
    resetn = 1'b0;
    #1 check_zero("rst_in_flight");
    tick(); tick();
    resetn = 1'b1;
    repeat (5) tick();
    check("no_rvalid_after_rst", rv_count - rc, 0);

    // First tie after reset goes to Conv2D
    c_valid = 1; c_addr = 5; c_we = 4'h0;
    p_valid = 1; p_addr = 9; p_we = 4'h0;
    @(negedge clk);
    check("rst_tie", {c_ready, p_ready}, 2'b10);
    tick();
    c_valid = 0; p_valid = 0;
    repeat (4) tick();
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mram_conv_port_a_arbiter.md
Name: mram_conv_port_a_arbiter

Overview:
- Shares Port A of the conv-model MRAM between two requesters: Conv2D (requester 0) and MaxPool (requester 1).
- Uses round-robin arbitration with valid/ready handshakes.
- Returns read data with a fixed latency.
- Includes a clear sequencer that zero-fills the whole MRAM on command.
- Sits between the CNN engine compute stages and the MRAM. Port B (RISC-V readout) is not touched.

Parameters:
- ADDR_WIDTH, 10: MRAM word-address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 32: word width; byte enables are DATA_WIDTH/8 = 4 bits.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- c_valid  in  1  Conv2D request valid.
- c_ready  out  1  Conv2D request accepted this cycle.
- c_addr  in  ADDR_WIDTH  Conv2D word address.
- c_wdata  in  DATA_WIDTH  Conv2D write data.
- c_we  in  4  Conv2D byte enables; 0 means read.
- c_rvalid  out  1  Conv2D read data valid.
- c_rdata  out  DATA_WIDTH  Conv2D read data.
- p_valid / p_ready / p_addr / p_wdata / p_we / p_rvalid / p_rdata  same widths and meanings for MaxPool.
- clear_start  in  1  single-cycle pulse requesting a zero-fill.
- clear_busy  out  1  high while the zero-fill is in progress.
- clear_done  out  1  single-cycle pulse when the zero-fill completes.
- mram_en_a  out  1  MRAM Port A enable.
- mram_we_a  out  4  MRAM Port A byte write enables.
- mram_addr_a  out  ADDR_WIDTH  MRAM Port A address.
- mram_din_a  out  DATA_WIDTH  MRAM Port A write data.
- mram_dout_a  in  DATA_WIDTH  MRAM Port A read data; registered in the MRAM, valid one cycle after mram_en_a.

Behaviour:
- Reset (asynchronous, active-low):
  - Every registered output goes to 0: mram_en_a, mram_we_a, mram_addr_a, mram_din_a, c_rvalid, p_rvalid, clear_busy, clear_done.
  - The state machine returns to SERVE.
  - The clear counter is set to 0 and the pending read pipeline is flushed.
  - The round-robin pointer last_grant is set to 1, so Conv2D wins the first tie.
  - Reset mid-clear or mid-read abandons the operation. No rvalid and no clear_done are produced afterwards.
- State machine, two states:
  - SERVE to CLEAR: when clear_start=1. clear_start takes priority over any request in that cycle; no handshake occurs in that cycle.
  - CLEAR to SERVE: after the write to address 2^ADDR_WIDTH-1 is issued.
  - clear_start while in CLEAR is ignored.
- Arbitration (SERVE only):
  - Grant is combinational. If only one requester is valid, it is granted.
  - If both are valid, grant the requester that is not last_grant.
  - ready = granted && state==SERVE && !clear_start. At most one ready is high per cycle.
  - On a handshake (valid && ready), last_grant is updated to the granted index.
  - The arbiter never stalls back-to-back requests: one handshake per cycle is possible.
- Memory issue:
  - A handshake in cycle N drives registered mram_en_a=1 with addr, din and we in cycle N+1.
  - With no handshake, mram_en_a=0 and mram_we_a=0; addr and din hold their last value.
- Read return:
  - A read handshake (we==0) in cycle N raises the owner's rvalid for exactly one cycle at N+2.
  - rdata = mram_dout_a, passed through combinationally to both requesters. Only the owner's rvalid qualifies it.
  - A write handshake produces no rvalid.
  - Tracking is a 2-stage pipeline of (valid, owner) bits. Reads from alternating requesters in consecutive cycles each return in order.
- Read-during-write: a read issued in the cycle after a write to the same address returns the new data. The MRAM registers writes at N+1, so the read at N+2 sees them.
- Clear:
  - In CLEAR, one write per cycle: mram_en_a=1, mram_we_a=4'hF, mram_din_a=0, mram_addr_a = counter.
  - The counter runs 0 to 2^ADDR_WIDTH-1, then wraps to 0.
  - clear_busy is high from the cycle after clear_start through the cycle of the last write.
  - clear_done pulses in the cycle after the last write.
  - Total duration is 2^ADDR_WIDTH write cycles.
  - Reads issued before clear_start still return their rvalid normally.

Test Plan:
- Reset, then c_valid=1, c_addr=5, c_we=4'hF, c_wdata=32'hDEADBEEF; next cycle read addr 5 -> write mram_en_a=1, we=F, addr=5 one cycle after the handshake; c_rvalid=1 with c_rdata=32'hDEADBEEF two cycles after the read handshake.
- Both requesters hold valid reads for 4 cycles -> grants go C,P,C,P; rvalids arrive in that order at +2 cycles each; never both ready in one cycle.
- Byte write: p_we=4'b0100, p_wdata=32'h00AA0000 to addr 9 holding 32'h11223344 -> read returns 32'h11AA3344.
- clear_start asserted in the same cycle as c_valid -> c_ready=0; clear_busy high for 1024 cycles with addresses 0..1023 and we=F; clear_done one-cycle pulse; reads afterwards return 0; c_ready resumes after the clear.
- resetn dropped mid-clear (counter=300) and with a read in flight -> all outputs go to 0 immediately; no clear_done and no rvalid after release; the next tie goes to Conv2D.
- clear_start pulsed again during CLEAR -> ignored; exactly one clear_done.
